// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the single-port program/data memory: one transaction at a time,
// round-robin between cpu (port 0) and loader/DMA (port 1), with a bounded lock for burst reads.
module mem_port_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 32,
    parameter int MEM_LAT  = 2,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_lock,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_lock,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner,
    output logic          busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
    localparam int LW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LAT);
    localparam logic [LW-1:0] LOCK_SAT = LW'(MAX_LOCK);

    logic [1:0]    state;
    logic [CW-1:0] wait_cnt;
    logic [LW-1:0] lock_cnt;
    logic          lock_held;
    logic          we_q;

    logic          owner_req;
    logic          other_req;
    logic          owner_lock;
    logic          grant_any;
    logic          grant_port;
    logic [LW-1:0] lock_cnt_nxt;

    assign busy = (state != IDLE);

    // Grant decision: a live lock wins until it has been honoured MAX_LOCK times,
    // then the other port gets a turn if it is waiting.
    always_comb begin
        owner_req    = owner ? m1_req  : m0_req;
        other_req    = owner ? m0_req  : m1_req;
        owner_lock   = owner ? m1_lock : m0_lock;
        grant_any    = m0_req | m1_req;
        grant_port   = owner;
        lock_cnt_nxt = lock_cnt;
        if (lock_held && owner_req && (lock_cnt < LOCK_SAT)) begin
            grant_port   = owner;
            lock_cnt_nxt = lock_cnt + 1'b1;
        end else if (other_req) begin
            grant_port   = ~owner;
            lock_cnt_nxt = '0;
        end else if (owner_req) begin
            grant_port   = owner;
            lock_cnt_nxt = lock_held ? LW'(1) : lock_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= 1'b1;
            lock_cnt  <= '0;
            lock_held <= 1'b0;
            wait_cnt  <= '0;
            we_q      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner     <= grant_port;
                        lock_cnt  <= lock_cnt_nxt;
                        we_q      <= grant_port ? m1_we    : m0_we;
                        mem_we    <= grant_port ? m1_we    : m0_we;
                        mem_addr  <= grant_port ? m1_addr  : m0_addr;
                        mem_wdata <= grant_port ? m1_wdata : m0_wdata;
                        mem_en    <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en   <= 1'b0;
                    mem_we   <= 1'b0;
                    wait_cnt <= LAT_LOAD;
                    state    <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt == CW'(1)) begin
                        if (!we_q) begin
                            if (owner) m1_rdata <= mem_rdata;
                            else       m0_rdata <= mem_rdata;
                        end
                        m0_ack <= ~owner;
                        m1_ack <= owner;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    m0_ack    <= 1'b0;
                    m1_ack    <= 1'b0;
                    lock_held <= owner_lock;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
